rpn_sequencer: RTL

- Initiator that drives the stack unit's opcode/data interface from a reverse-Polish token stream.
- Accepts operand/operator tokens over a valid/ready handshake and issues PUSH/ADD/MUL/POP opcodes.
- Tracks its own view of stack depth and detects underflow, full and leftover-operand errors.
- Returns one result, or one error, per expression on a valid/ready result port. Leaves the stack empty after every expression.

---
 rtl/rpn_pkg.sv | 27 ++
 rtl/rpn_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - stack opcodes, error codes and FSM states for rpn_sequencer
package rpn_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    ERR_OK        = 2'b00,
    ERR_UNDERFLOW = 2'b01,
    ERR_FULL      = 2'b10,
    ERR_LEFTOVER  = 2'b11
  } rpn_err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FINAL,
    S_CAPTURE,
    S_DRAIN_TOK,
    S_DRAIN_STK,
    S_RESULT
  } rpn_state_e;

endpackage

// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - drives a stack unit from a reverse-Polish token stream
// Define RPN_OVF_TRAP_EN to abort an expression on arithmetic overflow.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic             tok_op,
  input  logic [WIDTH-1:0] tok_value,
  input  logic             tok_last,
  output logic [2:0]       stk_opcode,
  output logic [WIDTH-1:0] stk_input_data,
  input  logic [WIDTH-1:0] stk_output_data,
  input  logic             stk_empty,
  input  logic             stk_full,
  input  logic             stk_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_err,
  output logic             res_ovf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE = DW'(1);
  localparam logic [DW-1:0] TWO = DW'(2);

  rpn_state_e       state, state_nxt;
  rpn_err_e         err, err_nxt;
  logic [DW-1:0]    depth, depth_nxt;
  logic [2:0]       opcode_nxt;
  logic [WIDTH-1:0] data_nxt, res_data_nxt;
  logic             ovf, ovf_nxt;
  logic             arith_d;
  logic             tok_fire, ovf_hit, trap, tok_bad;

  assign tok_fire = tok_valid & tok_ready;
  // arith_d marks the cycle in which the stack's overflow flag belongs to our last ADD/MUL
  assign ovf_hit  = arith_d & stk_overflow;
`ifdef RPN_OVF_TRAP_EN
  assign trap = ovf_hit;
`else
  assign trap = 1'b0;
`endif

  assign res_err = err;
  assign res_ovf = ovf;

  always_comb begin
    state_nxt    = state;
    depth_nxt    = depth;
    opcode_nxt   = OP_NOP;
    data_nxt     = stk_input_data;
    res_data_nxt = res_data;
    err_nxt      = err;
    ovf_nxt      = ovf | ovf_hit;
    tok_ready    = 1'b0;
    res_valid    = 1'b0;
    tok_bad      = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_RUN;
      S_RUN: begin
        tok_ready = 1'b1;
        if (tok_fire) begin
          if (trap) begin
            tok_bad = 1'b1;
          end else if (!tok_is_op) begin
            if (depth == DEPTH_MAX) begin
              tok_bad = 1'b1;
              err_nxt = ERR_FULL;
            end else begin
              opcode_nxt = OP_PUSH;
              data_nxt   = tok_value;
              depth_nxt  = depth + ONE;
            end
          end else if (depth < TWO) begin
            tok_bad = 1'b1;
            err_nxt = ERR_UNDERFLOW;
          end else begin
            opcode_nxt = tok_op ? OP_MUL : OP_ADD;
            depth_nxt  = depth - ONE;
          end
          if (tok_bad) state_nxt = tok_last ? S_DRAIN_STK : S_DRAIN_TOK;
          else if (tok_last) state_nxt = S_FINAL;
        end else if (trap) begin
          state_nxt = S_DRAIN_TOK;
        end
      end
      S_FINAL: begin
        if (trap) begin
          state_nxt = S_DRAIN_STK;
        end else if (depth == ONE) begin
          opcode_nxt = OP_POP;
          depth_nxt  = '0;
          state_nxt  = S_CAPTURE;
        end else begin
          err_nxt   = ERR_LEFTOVER;
          state_nxt = (depth != '0) ? S_DRAIN_STK : S_RESULT;
        end
      end
      S_CAPTURE: begin
        // Wait until the POP has been sampled so stk_output_data is the popped value
        if (trap) begin
          state_nxt = S_RESULT;
        end else if (stk_opcode != OP_POP) begin
          res_data_nxt = stk_output_data;
          state_nxt    = S_RESULT;
        end
      end
      S_DRAIN_TOK: begin
        tok_ready = 1'b1;
        if (tok_fire && tok_last) state_nxt = S_DRAIN_STK;
      end
      S_DRAIN_STK: begin
        if (depth != '0) begin
          opcode_nxt = OP_POP;
          depth_nxt  = depth - ONE;
        end else begin
          state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          err_nxt      = ERR_OK;
          ovf_nxt      = 1'b0;
          res_data_nxt = '0;
          state_nxt    = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      err            <= ERR_OK;
      depth          <= '0;
      stk_opcode     <= OP_NOP;
      stk_input_data <= '0;
      res_data       <= '0;
      ovf            <= 1'b0;
      arith_d        <= 1'b0;
    end else begin
      state          <= state_nxt;
      err            <= err_nxt;
      depth          <= depth_nxt;
      stk_opcode     <= opcode_nxt;
      stk_input_data <= data_nxt;
      res_data       <= res_data_nxt;
      ovf            <= ovf_nxt;
      arith_d        <= (stk_opcode == OP_ADD) || (stk_opcode == OP_MUL);
    end
  end

`ifndef SYNTHESIS
  // The stack lags our counter by the opcode still waiting to be sampled
  logic [DW:0] stk_depth;
  always_comb begin
    stk_depth = {1'b0, depth};
    case (stk_opcode)
      OP_PUSH:                stk_depth = stk_depth - 1'b1;
      OP_ADD, OP_MUL, OP_POP: stk_depth = stk_depth + 1'b1;
      default:                ;
    endcase
  end

  a_empty_match: assert property (@(posedge clk) disable iff (!rst_n)
    (stk_depth == '0) == stk_empty);
  a_full_match: assert property (@(posedge clk) disable iff (!rst_n)
    (stk_depth == (DW+1)'(DEPTH)) == stk_full);
`endif

endmodule
